dtw_sample_feeder: RTL
======================

Name: dtw_sample_feeder

Overview:
- Producer end of the DTW core's sample handshake. Holds one reference sequence and one camera sequence of SIZE samples each.
- Answers the core's ready_refer / ready_camera requests with samples in order, and drives the core's ready enable.
- Captures the core's score when the core signals done, and reports it to the host.
- Sits between the host/capture logic and the DTW engine. It replaces the free-running test sources.

Parameters:
- DATA_WIDTH, 10, sample and score width.
- SIZE, 20, samples per sequence (both buffers).
- TIMEOUT_CYCLES, 4096, maximum RUN cycles without done before the block declares an error.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  host writes load_data into the buffer chosen by load_sel.
- load_sel  in  1  0 = reference buffer, 1 = camera buffer.
- load_data  in  DATA_WIDTH  sample to store.
- load_ready  out  1  high when loads are accepted (IDLE only).
- clear  in  1  empties both buffers (IDLE only).
- start  in  1  begins a comparison run.
- ready  out  1  run enable to the DTW core.
- ready_refer  in  1  core requests the next reference sample.
- ready_camera  in  1  core consumes the current camera sample.
- refer  out  DATA_WIDTH  reference sample to the core.
- camera  out  DATA_WIDTH  camera sample to the core.
- done  in  1  core finished; score is valid this cycle.
- score  in  DATA_WIDTH  core result.
- result  out  DATA_WIDTH  captured score.
- result_valid  out  1  one-cycle pulse when result updates.
- busy  out  1  high in RUN.
- underrun  out  1  sticky: the core requested more than SIZE samples from a buffer.
- err  out  1  timeout occurred.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: every output is 0, both buffers are empty, all pointers are 0, state is IDLE. The buffer contents array is not reset.
- States: IDLE, RUN, DONE, ERR. Encoding is 2 bits.
- IDLE:
  - load_ready = 1.
  - load_valid writes the selected buffer at its write pointer, then increments that pointer. A write to a full buffer (pointer == SIZE) is dropped.
  - clear zeroes both write pointers and takes priority over a simultaneous load.
  - start is honoured only when both buffers hold SIZE samples; otherwise it is ignored. When honoured: read pointers, underrun, err and the timeout counter are zeroed; camera is registered with cam[0]; the next state is RUN.
- RUN:
  - busy = 1, ready = 1, load_ready = 0. load_valid, clear and start are ignored.
  - Reference request:
    - In a cycle with ready_refer = 1 and ref_rd < SIZE, refer <= ref[ref_rd] and ref_rd increments. refer is valid from the next cycle and held until the next request.
    - If ref_rd == SIZE, refer <= 0 and underrun is set.
  - Camera request:
    - camera always shows the current sample, combinationally usable by the core in the cycle it raises ready_camera.
    - In a cycle with ready_camera = 1, cam_rd increments and camera <= cam[cam_rd+1], visible the next cycle.
    - Once past the last sample, camera <= 0 and underrun is set.
  - ready_refer and ready_camera in the same cycle are both served independently.
  - done = 1: result <= score; the next state is DONE. A done that coincides with a request still serves that request.
  - Timeout counter increments each RUN cycle. Reaching TIMEOUT_CYCLES-1 without done → ERR.
- DONE: result_valid = 1 for exactly one cycle, ready = 0, then IDLE. Buffer contents are retained, so start can rerun without reloading.
- ERR: err = 1, ready = 0, result unchanged. start or clear returns to IDLE, and err is cleared on that transition.
- Latency: done to result_valid is 1 cycle. ready_refer to refer valid is 1 cycle.
- Reset mid-run: all state returns immediately to reset values and ready drops asynchronously. The buffers are then empty and must be reloaded.
- Widths: pointers are $clog2(SIZE)+1 bits; the timeout counter is $clog2(TIMEOUT_CYCLES) bits. No arithmetic is performed on sample data.

Decomposition:
- Package dtw_pkg: feeder state enum typedef, DTW_PAD constant (0), and a helper for the pointer-width localparam.
- One sub-module, dtw_sample_buffer (SIZE x DATA_WIDTH, write port, write pointer, full flag, indexed read). It is instantiated twice, once for reference and once for camera.

Test Plan:
- Load 20 ref (1..20) and 20 cam (100..119), start, then pulse ready_refer 3 times → refer reads 1, 2, 3 on the cycle after each pulse; camera reads 100 until the first ready_camera, then 101.
- Load only 19 cam samples, start → stays IDLE, ready = 0. Load the 20th sample, start → RUN.
- In RUN, drive done = 1 with score = 0x05A → result = 0x05A and a single-cycle result_valid one cycle later. Start again with no reload → RUN begins with camera = 100.
- Issue 21 ready_refer pulses → the 21st yields refer = 0 and underrun = 1, which stays high until the next honoured start.
- In RUN with TIMEOUT_CYCLES = 16 and no done → err = 1 and ready = 0 after 16 cycles. Start → IDLE, err = 0.
- Assert rst_n low mid-RUN → ready, busy, result and all flags go to 0 immediately. load_ready is 1 after release and both buffers read as empty.

Source files
------------

// File: rtl/dtw_pkg.sv
// Shared types and helpers for the DTW sample feeder and its buffers.
package dtw_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2,
    StErr  = 2'd3
  } feeder_state_e;

  // Value presented to the core once a sequence is exhausted.
  localparam int unsigned DTW_PAD = 0;

  // One extra bit so a pointer can hold SIZE itself (the "full"/"exhausted" mark).
  function automatic int unsigned ptr_width(input int unsigned size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/dtw_sample_buffer.sv
// SIZE-deep sample store with a fill pointer and an indexed combinational read.
module dtw_sample_buffer
  import dtw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned SIZE       = 20,
  parameter int unsigned PTR_WIDTH  = ptr_width(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [PTR_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full
);

  localparam int unsigned IdxW = (SIZE > 1) ? $clog2(SIZE) : 1;

  logic [DATA_WIDTH-1:0] mem [SIZE];
  logic [PTR_WIDTH-1:0]  wr_ptr_q;
  logic                  wr_fire;

  assign full    = (wr_ptr_q == PTR_WIDTH'(SIZE));
  assign wr_fire = wr_en && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
    end else if (wr_fire) begin
      wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
    end
  end

  // Contents are deliberately not reset; the fill pointer alone defines validity.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_q[IdxW-1:0]] <= wr_data;
    end
  end

  assign rd_data = (rd_idx < PTR_WIDTH'(SIZE)) ? mem[rd_idx[IdxW-1:0]]
                                                : DATA_WIDTH'(DTW_PAD);

endmodule

// File: rtl/dtw_sample_feeder.sv
// Producer side of the DTW core sample handshake: buffers two sequences, feeds them on
// request, captures the score and flags underrun / timeout.
module dtw_sample_feeder
  import dtw_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 10,
  parameter int unsigned SIZE           = 20,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic                  load_sel,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  input  logic                  clear,
  input  logic                  start,
  output logic                  ready,
  input  logic                  ready_refer,
  input  logic                  ready_camera,
  output logic [DATA_WIDTH-1:0] refer,
  output logic [DATA_WIDTH-1:0] camera,
  input  logic                  done,
  input  logic [DATA_WIDTH-1:0] score,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  underrun,
  output logic                  err
);

  localparam int unsigned PtrW = ptr_width(SIZE);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES);

  feeder_state_e         state_q, state_d;
  logic [PtrW-1:0]       ref_rd_q, ref_rd_d, cam_rd_q, cam_rd_d, cam_idx;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] refer_q, refer_d, camera_q, camera_d, result_q, result_d;
  logic                  underrun_q, underrun_d;
  logic [DATA_WIDTH-1:0] ref_rd_data, cam_rd_data;
  logic                  ref_full, cam_full;
  logic                  idle, buf_clr, ref_we, cam_we, start_ok;

  assign idle     = (state_q == StIdle);
  assign buf_clr  = idle && clear;
  assign ref_we   = idle && load_valid && !clear && !load_sel;
  assign cam_we   = idle && load_valid && !clear && load_sel;
  assign start_ok = idle && start && !clear && ref_full && cam_full;
  // In IDLE the camera port looks at sample 0 so start can preload it.
  assign cam_idx  = idle ? '0 : cam_rd_q + PtrW'(1);

  dtw_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .PTR_WIDTH  (PtrW)
  ) u_ref_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .wr_en   (ref_we),
    .wr_data (load_data),
    .rd_idx  (ref_rd_q),
    .rd_data (ref_rd_data),
    .full    (ref_full)
  );

  dtw_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .PTR_WIDTH  (PtrW)
  ) u_cam_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (buf_clr),
    .wr_en   (cam_we),
    .wr_data (load_data),
    .rd_idx  (cam_idx),
    .rd_data (cam_rd_data),
    .full    (cam_full)
  );

  always_comb begin
    state_d    = state_q;
    ref_rd_d   = ref_rd_q;
    cam_rd_d   = cam_rd_q;
    tmo_d      = tmo_q;
    refer_d    = refer_q;
    camera_d   = camera_q;
    result_d   = result_q;
    underrun_d = underrun_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          ref_rd_d   = '0;
          cam_rd_d   = '0;
          tmo_d      = '0;
          underrun_d = 1'b0;
          camera_d   = cam_rd_data;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (ready_refer) begin
          if (ref_rd_q < PtrW'(SIZE)) begin
            refer_d  = ref_rd_data;
            ref_rd_d = ref_rd_q + PtrW'(1);
          end else begin
            refer_d    = DATA_WIDTH'(DTW_PAD);
            underrun_d = 1'b1;
          end
        end
        // cam_rd_data already reads cam_rd+1 and pads past the end.
        if (ready_camera) begin
          if (cam_rd_q < PtrW'(SIZE)) begin
            cam_rd_d = cam_rd_q + PtrW'(1);
            camera_d = cam_rd_data;
          end else begin
            camera_d   = DATA_WIDTH'(DTW_PAD);
            underrun_d = 1'b1;
          end
        end
        if (done) begin
          result_d = score;
          state_d  = StDone;
        end else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          state_d = StErr;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StDone: state_d = StIdle;
      StErr: begin
        if (start || clear) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ref_rd_q   <= '0;
      cam_rd_q   <= '0;
      tmo_q      <= '0;
      refer_q    <= '0;
      camera_q   <= '0;
      result_q   <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_rd_q   <= ref_rd_d;
      cam_rd_q   <= cam_rd_d;
      tmo_q      <= tmo_d;
      refer_q    <= refer_d;
      camera_q   <= camera_d;
      result_q   <= result_d;
      underrun_q <= underrun_d;
    end
  end

  // load_ready is qualified with rst_n so every output reads 0 while reset is held.
  assign load_ready   = idle && rst_n;
  assign ready        = (state_q == StRun);
  assign busy         = (state_q == StRun);
  assign result_valid = (state_q == StDone);
  assign err          = (state_q == StErr);
  assign refer        = refer_q;
  assign camera       = camera_q;
  assign result       = result_q;
  assign underrun     = underrun_q;

endmodule
